// File: rtl/rtc_hms_display_if.sv
// Time-set bus for rtc_hms_display.
// A requester (master) presents hh/mm/ss with set_valid and holds them until
// it samples set_ready high; the clock block (slave) answers with set_ready
// and a one-cycle set_err pulse when an accepted load is out of range.
//   set_valid  master -> slave  load request
//   set_hh     master -> slave  hour, binary 0-23
//   set_mm     master -> slave  minute, binary 0-59
//   set_ss     master -> slave  second, binary 0-59
//   set_ready  slave  -> master load can be accepted this cycle
//   set_err    slave  -> master accepted load was rejected
interface rtc_hms_display_if;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hh;
    logic [5:0] set_mm;
    logic [5:0] set_ss;
    logic       set_err;

    modport master (
        output set_valid, set_hh, set_mm, set_ss,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hh, set_mm, set_ss,
        output set_ready, set_err
    );
endinterface

// File: rtl/rtc_hms_display.sv
// HH:MM:SS time-of-day counter driving six 7-segment digits.
// A prescaler divides clk down to one tick per second; seconds and minutes
// are kept as BCD digit pairs, hours in binary. A two-state load FSM accepts
// a new time over set_bus, range-checks it and either applies it or flags it.
// Digits and pm are registered, so they follow the time state by one cycle.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   switch     display mode: 0 = 24 h, 1 = 12 h
//   set_bus    time-load handshake (slave side)
//   tick_1hz   one-cycle pulse on every second increment
//   pm         12 h mode: hour >= 12; 24 h mode: 0
//   led_a..f   segment codes (bit6..0 = a..g): sec ones, sec tens,
//              min ones, min tens, hr ones, hr tens
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | ready for a load; time advances on prescaler wrap
// APPLY  | holding regs range-checked; valid load written, else set_err
module rtc_hms_display #(
    parameter int CLK_HZ         = 50_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_HR_TENS  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               switch,
    rtc_hms_display_if.slave   set_bus,
    output logic               tick_1hz,
    output logic               pm,
    output logic [6:0]         led_a,
    output logic [6:0]         led_b,
    output logic [6:0]         led_c,
    output logic [6:0]         led_d,
    output logic [6:0]         led_e,
    output logic [6:0]         led_f
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW ? 7'b0000001 : 7'b1111110;

    typedef enum logic {ST_RUN, ST_APPLY} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic          wrap;
    logic          accept;
    logic          apply_ok;
    logic          hold_ok;
    logic [4:0]    hold_hh;
    logic [5:0]    hold_mm;
    logic [5:0]    hold_ss;

    logic [3:0]    sec_o, min_o;
    logic [2:0]    sec_t, min_t;
    logic [4:0]    hour;

    logic [6:0]    ld_min, ld_sec;
    logic [4:0]    hr_disp;
    logic [3:0]    hr_t, hr_o;

    // Binary 0-59 to {tens[2:0], ones[3:0]}; only used on range-checked values.
    function automatic logic [6:0] to_bcd(input logic [5:0] v);
        logic [2:0] t;
        logic [5:0] base;
        if (v >= 6'd50) begin
            t = 3'd5; base = 6'd50;
        end else if (v >= 6'd40) begin
            t = 3'd4; base = 6'd40;
        end else if (v >= 6'd30) begin
            t = 3'd3; base = 6'd30;
        end else if (v >= 6'd20) begin
            t = 3'd2; base = 6'd20;
        end else if (v >= 6'd10) begin
            t = 3'd1; base = 6'd10;
        end else begin
            t = 3'd0; base = 6'd0;
        end
        return {t, 4'(v - base)};
    endfunction

    // Anything outside 0-9 decodes to blank so stray values never light junk.
    function automatic logic [6:0] seg(input logic [3:0] d, input logic blank);
        logic [6:0] c;
        if (blank) begin
            c = 7'b1111111;
        end else begin
            case (d)
                4'd0:    c = 7'b0000001;
                4'd1:    c = 7'b1001111;
                4'd2:    c = 7'b0010010;
                4'd3:    c = 7'b0000110;
                4'd4:    c = 7'b1001100;
                4'd5:    c = 7'b0100100;
                4'd6:    c = 7'b0100000;
                4'd7:    c = 7'b0001111;
                4'd8:    c = 7'b0000000;
                4'd9:    c = 7'b0000100;
                default: c = 7'b1111111;
            endcase
        end
        return SEG_ACTIVE_LOW ? c : ~c;
    endfunction

    // ---------------- load FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (set_bus.set_valid) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        set_bus.set_ready = (state == ST_RUN);
        set_bus.set_err   = (state == ST_APPLY) && !hold_ok;
        accept            = (state == ST_RUN) && set_bus.set_valid;
        apply_ok          = (state == ST_APPLY) && hold_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_hh <= '0;
            hold_mm <= '0;
            hold_ss <= '0;
        end else if (accept) begin
            hold_hh <= set_bus.set_hh;
            hold_mm <= set_bus.set_mm;
            hold_ss <= set_bus.set_ss;
        end
    end

    assign hold_ok = (hold_hh < 5'd24) && (hold_mm < 6'd60) && (hold_ss < 6'd60);
    assign ld_min  = to_bcd(hold_mm);
    assign ld_sec  = to_bcd(hold_ss);

    // ---------------- prescaler ----------------
    assign wrap = (presc == PW'(CLK_HZ - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                presc <= '0;
        else if (apply_ok || wrap) presc <= '0;
        else                       presc <= presc + PW'(1);
    end

    // A valid load in the wrap cycle takes priority and swallows that tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_1hz <= 1'b0;
        else        tick_1hz <= wrap && !apply_ok;
    end

    // ---------------- time state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_o <= '0;
            sec_t <= '0;
            min_o <= '0;
            min_t <= '0;
            hour  <= '0;
        end else if (apply_ok) begin
            sec_o <= ld_sec[3:0];
            sec_t <= ld_sec[6:4];
            min_o <= ld_min[3:0];
            min_t <= ld_min[6:4];
            hour  <= hold_hh;
        end else if (wrap) begin
            if (sec_o != 4'd9) begin
                sec_o <= sec_o + 4'd1;
            end else begin
                sec_o <= '0;
                if (sec_t != 3'd5) begin
                    sec_t <= sec_t + 3'd1;
                end else begin
                    sec_t <= '0;
                    if (min_o != 4'd9) begin
                        min_o <= min_o + 4'd1;
                    end else begin
                        min_o <= '0;
                        if (min_t != 3'd5) begin
                            min_t <= min_t + 3'd1;
                        end else begin
                            min_t <= '0;
                            hour  <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- display ----------------
    always_comb begin
        hr_disp = hour;
        if (switch) begin
            if (hour == 5'd0)       hr_disp = 5'd12;
            else if (hour > 5'd12)  hr_disp = hour - 5'd12;
        end
        if (hr_disp >= 5'd20) begin
            hr_t = 4'd2;
            hr_o = 4'(hr_disp - 5'd20);
        end else if (hr_disp >= 5'd10) begin
            hr_t = 4'd1;
            hr_o = 4'(hr_disp - 5'd10);
        end else begin
            hr_t = 4'd0;
            hr_o = hr_disp[3:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_a <= SEG_ZERO;
            led_b <= SEG_ZERO;
            led_c <= SEG_ZERO;
            led_d <= SEG_ZERO;
            led_e <= SEG_ZERO;
            led_f <= SEG_ZERO;
            pm    <= 1'b0;
        end else begin
            led_a <= seg(sec_o, 1'b0);
            led_b <= seg({1'b0, sec_t}, 1'b0);
            led_c <= seg(min_o, 1'b0);
            led_d <= seg({1'b0, min_t}, 1'b0);
            led_e <= seg(hr_o, 1'b0);
            led_f <= seg(hr_t, BLANK_HR_TENS && (hr_t == 4'd0));
            pm    <= switch && (hour >= 5'd12);
        end
    end

endmodule

// File: tb/tb_rtc_hms_display.sv
module tb_rtc_hms_display;

    localparam int CLK_HZ = 10;
    localparam bit SEG_AL = 1'b1;
    localparam bit BLANK  = 1'b0;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef struct packed {
        logic [41:0] leds;
        logic        pm;
        logic        tick;
        logic        ready;
        logic        err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       sw;
    logic       tick_1hz, pm;
    logic [6:0] led_a, led_b, led_c, led_d, led_e, led_f;

    rtc_hms_display_if bus ();

    rtc_hms_display #(
        .CLK_HZ         (CLK_HZ),
        .SEG_ACTIVE_LOW (SEG_AL),
        .BLANK_HR_TENS  (BLANK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .switch   (sw),
        .set_bus  (bus),
        .tick_1hz (tick_1hz),
        .pm       (pm),
        .led_a    (led_a),
        .led_b    (led_b),
        .led_c    (led_c),
        .led_d    (led_d),
        .led_e    (led_e),
        .led_f    (led_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    bit   started = 0;

    // reference model: time of day as a plain count of seconds
    int   m_secs  = 0;
    int   m_presc = 0;
    bit   m_apply = 0;
    int   h_hh = 0, h_mm = 0, h_ss = 0;
    bit   drv_rst = 0;
    bit   drv_sw  = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_exp(int d, bit blank);
        logic [6:0] c;
        c = blank ? 7'b1111111 : SEG_TBL[d];
        return SEG_AL ? c : ~c;
    endfunction

    function automatic logic [41:0] disp_exp(int secs, bit mode12);
        int hr, mn, sc, h;
        hr = secs / 3600;
        mn = (secs / 60) % 60;
        sc = secs % 60;
        h  = mode12 ? ((hr % 12 == 0) ? 12 : hr % 12) : hr;
        return {seg_exp(sc % 10, 0), seg_exp(sc / 10, 0),
                seg_exp(mn % 10, 0), seg_exp(mn / 10, 0),
                seg_exp(h % 10, 0),  seg_exp(h / 10, BLANK && (h / 10 == 0))};
    endfunction

    function automatic bit hold_valid();
        return (h_hh < 24) && (h_mm < 60) && (h_ss < 60);
    endfunction

    // Advance the model across the coming rising edge; queue the outputs it predicts.
    task automatic step();
        exp_t e;
        bit   wrap;
        if (!reset) begin
            m_secs  = 0;
            m_presc = 0;
            m_apply = 0;
            e.leds  = {6{seg_exp(0, 0)}};
            e.pm    = 1'b0;
            e.tick  = 1'b0;
            e.ready = 1'b1;
            e.err   = 1'b0;
        end else begin
            e.leds = disp_exp(m_secs, sw);
            e.pm   = sw && (m_secs / 3600 >= 12);
            e.tick = 1'b0;
            wrap   = (m_presc == CLK_HZ - 1);
            if (m_apply && hold_valid()) begin
                m_secs  = h_hh * 3600 + h_mm * 60 + h_ss;
                m_presc = 0;
            end else if (wrap) begin
                m_secs  = (m_secs + 1) % 86400;
                m_presc = 0;
                e.tick  = 1'b1;
            end else begin
                m_presc++;
            end
            if (m_apply) begin
                m_apply = 0;
            end else if (bus.set_valid) begin
                h_hh    = int'(bus.set_hh);
                h_mm    = int'(bus.set_mm);
                h_ss    = int'(bus.set_ss);
                m_apply = 1;
            end
            e.ready = !m_apply;
            e.err   = m_apply && !hold_valid();
        end
        q.push_back(e);
        started = 1;
    endtask

    task automatic cyc(bit v, int hh, int mm, int ss);
        @(negedge clk);
        reset         = drv_rst;
        sw            = drv_sw;
        bus.set_valid = v;
        bus.set_hh    = 5'(hh);
        bus.set_mm    = 6'(mm);
        bus.set_ss    = 6'(ss);
        step();
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic load(int hh, int mm, int ss);
        if (m_apply) cyc(0, 0, 0, 0);
        cyc(1, hh, mm, ss);
    endtask

    task automatic wait_presc(int target);
        for (int i = 0; i < 3 * CLK_HZ && (m_presc != target || m_apply); i++)
            cyc(0, 0, 0, 0);
    endtask

    // Pull reset low between edges and check the outputs without any clock.
    task automatic async_reset_check(string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, " leds"},  64'({led_a, led_b, led_c, led_d, led_e, led_f}),
            64'({6{seg_exp(0, 0)}}));
        chk({tag, " pm"},    64'(pm), 64'(0));
        chk({tag, " tick"},  64'(tick_1hz), 64'(0));
        chk({tag, " ready"}, 64'(bus.set_ready), 64'(1));
        chk({tag, " err"},   64'(bus.set_err), 64'(0));
        drv_rst = 1'b0;
    endtask

    // monitor: compare every post-edge output against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                if (started) chk("queue underrun", 64'(0), 64'(1));
            end else begin
                e = q.pop_front();
                chk("leds",  64'({led_a, led_b, led_c, led_d, led_e, led_f}), 64'(e.leds));
                chk("pm",    64'(pm), 64'(e.pm));
                chk("tick",  64'(tick_1hz), 64'(e.tick));
                chk("ready", 64'(bus.set_ready), 64'(e.ready));
                chk("err",   64'(bus.set_err), 64'(e.err));
            end
        end
    end

    initial begin
        reset         = 1'b0;
        sw            = 1'b0;
        bus.set_valid = 1'b0;
        bus.set_hh    = '0;
        bus.set_mm    = '0;
        bus.set_ss    = '0;

        // reset state, then first second
        idle(3);
        drv_rst = 1'b1;
        idle(12);

        // midnight rollover
        load(23, 59, 59);
        idle(14);

        // 12 h display
        drv_sw = 1'b1;
        load(13, 5, 0);
        idle(3);
        load(0, 0, 0);
        idle(3);
        load(12, 30, 45);
        idle(3);
        drv_sw = 1'b0;
        idle(2);

        // out-of-range loads
        load(24, 0, 0);
        idle(3);
        load(5, 60, 0);
        idle(2);
        load(5, 0, 60);
        idle(2);

        // load applied in the wrap cycle suppresses that tick
        wait_presc(CLK_HZ - 2);
        cyc(1, 10, 20, 30);
        idle(13);
        // rejected load in the wrap cycle lets the tick through
        wait_presc(CLK_HZ - 2);
        cyc(1, 25, 0, 0);
        idle(3);
        // wrap during the accept cycle
        wait_presc(CLK_HZ - 1);
        cyc(1, 1, 2, 3);
        idle(3);
        // valid held high: re-accepted every other cycle
        cyc(1, 4, 5, 6);
        cyc(1, 4, 5, 6);
        cyc(1, 7, 8, 9);
        cyc(1, 7, 8, 9);
        idle(3);

        // async reset mid-APPLY and mid-second
        cyc(1, 11, 11, 11);
        async_reset_check("rst apply");
        idle(2);
        drv_rst = 1'b1;
        idle(7);
        async_reset_check("rst second");
        idle(2);
        drv_rst = 1'b1;
        idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int hh, mm, ss;
            if ($urandom_range(0, 99) < 3) drv_sw = ~drv_sw;
            if ($urandom_range(0, 99) < 30) begin
                hh = 23;
                mm = 59;
                ss = $urandom_range(50, 59);
            end else begin
                hh = $urandom_range(0, 26);
                mm = $urandom_range(0, 62);
                ss = $urandom_range(0, 62);
            end
            cyc($urandom_range(0, 99) < 15, hh, mm, ss);
        end
        idle(2);

        @(posedge clk);
        #3;
        chk("queue drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
